// File: rtl/adder_share_arb_pkg.sv
// rtl/adder_share_arb_pkg.sv - shared opcode and FSM state definitions for adder_share_arb
package adder_share_arb_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/adder_share_arb_rr_arbiter.sv
// rtl/adder_share_arb_rr_arbiter.sv - round-robin arbiter, search starts at ptr_i
module adder_share_arb_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    any_o = found;
    // Index is still reported when disabled so the datapath mux stays defined.
    grant_o[idx_o] = found & en_i;
  end

endmodule

// File: rtl/adder_share_arb.sv
// rtl/adder_share_arb.sv - one registered add/sub datapath shared round-robin among NREQ requesters
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 5,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_s,
  output logic                  rsp_cout
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
  logic             rsp_cout_q, rsp_cout_d;

  logic             can_issue, any_req, issue;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] a_sel, b_sel, b_x, sum;
  logic             sub_sel;
  logic [WIDTH:0]   carry;

  assign can_issue = (state_q == ST_IDLE) | rsp_ready;
  assign issue     = can_issue & any_req;

  adder_share_arb_rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req_i  (req_valid),
    .ptr_i  (rr_ptr_q),
    .en_i   (can_issue),
    .grant_o(req_ready),
    .idx_o  (gnt_idx),
    .any_o  (any_req)
  );

  assign a_sel   = req_a[gnt_idx*WIDTH +: WIDTH];
  assign b_sel   = req_b[gnt_idx*WIDTH +: WIDTH];
  assign sub_sel = req_sub[gnt_idx];
  assign b_x     = b_sel ^ {WIDTH{sub_sel}};

  // Full-adder ripple chain; subtract injects the +1 of two's complement as carry-in.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = sub_sel;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = a_sel[i] ^ b_x[i] ^ carry[i];
      carry[i+1] = (a_sel[i] & b_x[i]) | (carry[i] & (a_sel[i] ^ b_x[i]));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_s_d    = rsp_s_q;
    rsp_cout_d = rsp_cout_q;
    if (issue) begin
      state_d    = ST_RESP;
      rsp_id_d   = gnt_idx;
      rsp_s_d    = sum;
      rsp_cout_d = carry[WIDTH];
      rr_ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (state_q == ST_RESP && rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_s_q    <= '0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_s_q    <= rsp_s_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// tb/tb_adder_share_arb.sv - scoreboard bench for adder_share_arb with directed vectors
module tb_adder_share_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 5;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_s;
  logic                  rsp_cout;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_sub  (req_sub),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_s    (rsp_s),
    .rsp_cout (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b, input logic sub);
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    req_sub[i]              = sub;
    req_valid[i]            = 1'b1;
  endtask

  task automatic push(input int id, input int s, input int cout);
    exp_q.push_back({IDW'(id), WIDTH'(s), 1'(cout)});
  endtask

  // Monitor: every accepted response must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_id), 32'hFFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("rsp_id",   32'(rsp_id),   32'(e[7:6]));
        chk("rsp_s",    32'(rsp_s),    32'(e[5:1]));
        chk("rsp_cout", 32'(rsp_cout), 32'(e[0]));
      end
    end
  end

  logic [3:0] all_ids [5];
  int         all_s   [4];
  int         all_c   [4];

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id",    32'(rsp_id),    0);
    chk("rst_rsp_s",     32'(rsp_s),     0);
    chk("rst_rsp_cout",  32'(rsp_cout),  0);
    chk("rst_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    step();

    // Single add from requester 0
    rsp_ready = 1'b1;
    set_req(0, 3, 4, 1'b0);
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    push(0, 7, 0);
    step();
    req_valid = '0;
    chk("t1_valid", 32'(rsp_valid), 1);
    step();
    chk("t1_idle", 32'(rsp_valid), 0);

    // Subtracts from requester 1, back to back
    set_req(1, 5, 3, 1'b1);
    #1 chk("t2_ready_a", 32'(req_ready), 32'b0010);
    push(1, 2, 1);
    step();
    set_req(1, 3, 5, 1'b1);
    #1 chk("t2_ready_b", 32'(req_ready), 32'b0010);
    push(1, 30, 0);
    step();
    req_valid = '0;

    // Wrap-around add and zero subtract
    set_req(2, 31, 1, 1'b0);
    #1 chk("t3_ready_a", 32'(req_ready), 32'b0100);
    push(2, 0, 1);
    step();
    req_valid = '0;
    set_req(3, 0, 0, 1'b1);
    #1 chk("t3_ready_b", 32'(req_ready), 32'b1000);
    push(3, 0, 1);
    step();
    req_valid = '0;
    step();

    // All requesters valid: grants rotate 0,1,2,3,0
    set_req(0, 10, 5, 1'b0);
    set_req(1, 20, 15, 1'b0);
    set_req(2, 7, 9, 1'b1);
    set_req(3, 9, 7, 1'b1);
    all_s = '{15, 3, 30, 2};
    all_c = '{0, 1, 0, 1};
    all_ids = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      #1 chk("t4_rr_grant", 32'(req_ready), 32'(4'b0001 << all_ids[k]));
      push(int'(all_ids[k]), all_s[all_ids[k]], all_c[all_ids[k]]);
      step();
    end
    req_valid = '0;
    step();
    step();

    // Back-pressure: response held, no grants, next grant on release
    set_req(1, 6, 2, 1'b0);
    #1 chk("t5_ready", 32'(req_ready), 32'b0010);
    push(1, 8, 0);
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    set_req(2, 1, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_stall_ready", 32'(req_ready), 0);
      chk("t5_stall_valid", 32'(rsp_valid), 1);
      chk("t5_stall_s",     32'(rsp_s),     8);
      chk("t5_stall_id",    32'(rsp_id),    1);
      step();
    end
    rsp_ready = 1'b1;
    #1 chk("t5_release_ready", 32'(req_ready), 32'b0100);
    push(2, 2, 0);
    step();
    req_valid = '0;
    step();

    // Reset while holding a result with rr_ptr=2
    set_req(1, 1, 1, 1'b0);
    #1 chk("t6_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("t6_held", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 0);
    chk("t6_rst_s",     32'(rsp_s),     0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 2, 1, 1'b1);
    set_req(2, 4, 4, 1'b0);
    #1 chk("t6_first_grant", 32'(req_ready), 32'b0001);
    push(0, 1, 1);
    step();
    chk("t6_second_grant", 32'(req_ready), 32'b0100);
    push(2, 8, 0);
    step();
    req_valid = '0;
    step();
    step();

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
